// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front-end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;

    // Fetch sequencer state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // One fetched instruction with the PC it was fetched from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with flush.
// Ports: clk_i/rst_i (async active-low), push_i/wdata_i write side,
//        pop_i/rdata_c read side (head, combinational from storage),
//        flush_i empties the queue (wins over push/pop),
//        count_o registered occupancy, full_c/empty_c status.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_c,
    output logic [CNT_W-1:0] count_o,
    output logic             full_c,
    output logic             empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign rdata_c = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_c && !flush_i;
        do_pop   = pop_i && !empty_c && !flush_i;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues credit-limited
// word requests over req/gnt/rvalid, queues responses in order and hands
// {inst, pc} to decode over valid/ready. A redirect flushes the queue and
// marks every in-flight request to be dropped on return.
// Ports: clk_i, rst_i (async active-low); start_i fetch enable;
//        redirect_i/redirect_pc_i restart; imem_* memory request/response;
//        inst_valid_o/inst_o/inst_pc_o/inst_ready_i decode handshake.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    fetch_state_e       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   inst_count, out_count;
    logic [ENTRY_W-1:0] inst_head_raw;
    fetch_entry_t       inst_head, inst_wdata;
    logic [31:0]        pc_head;
    logic               inst_full, inst_empty, pc_full, pc_empty;
    logic               grant, accept, pop;

    // Sequencer: next state and request qualification
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                // Credit covers buffered entries plus every in-flight request,
                // including those already marked for dropping.
                imem_req_o = !pc_full &&
                    ((SUM_W'(inst_count) + SUM_W'(out_count)) < SUM_W'(DEPTH));
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: PC update, response accept/drop, decode handshake
    always_comb begin
        grant        = imem_req_o && imem_gnt_i;
        accept       = imem_rvalid_i && !pc_empty && (drop_q == '0);
        inst_valid_o = !inst_empty && !redirect_i;
        pop          = inst_valid_o && inst_ready_i;
        inst_wdata   = '{inst: imem_rdata_i, pc: pc_head};
        inst_head    = fetch_entry_t'(inst_head_raw);

        pc_d = pc_q;
        if (grant) pc_d = pc_q + 32'(PC_STEP);
        if (redirect_i) pc_d = {redirect_pc_i[31:2], 2'b00};

        drop_d = drop_q;
        if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        // Everything still in flight after this edge belongs to the old stream
        if (redirect_i) begin
            drop_d = CNT_W'(SUM_W'(out_count) + SUM_W'(grant) - SUM_W'(imem_rvalid_i));
        end
    end

    assign imem_addr_o = pc_q;
    assign inst_o      = inst_head.inst;
    assign inst_pc_o   = inst_head.pc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // Decoded-instruction queue
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_inst_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (inst_wdata),
        .rdata_c (inst_head_raw),
        .count_o (inst_count),
        .full_c  (inst_full),
        .empty_c (inst_empty)
    );

    // PCs of in-flight requests; popped by every response, dropped or not
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNT_W (CNT_W)
    ) u_pc_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .pop_i   (imem_rvalid_i),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_c (pc_head),
        .count_o (out_count),
        .full_c  (pc_full),
        .empty_c (pc_empty)
    );

    // Credit rule must keep the instruction queue from overflowing
    assert property (@(posedge clk_i) disable iff (!rst_i)
        !(accept && inst_full && !redirect_i));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model:
// in-flight requests are a queue of {pc, dropped} records, the decode queue
// is a queue of {inst, pc}, and a memory stub returns data derived from the
// address with random grant and response timing.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, redirect_i, imem_gnt_i, imem_rvalid_i, inst_ready_i;
    logic [31:0] redirect_pc_i, imem_rdata_i;
    logic        imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, inst_pc_o;

    always #5 clk_i = ~clk_i;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_STEP  (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
    );

    typedef struct {
        logic [31:0] pc;
        bit          drop;
    } flight_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference state
    bit           m_run;
    logic [31:0]  m_pc;
    flight_t      m_out[$];
    fetch_entry_t m_q[$];
    // Memory stub: addresses granted by the DUT, awaiting response
    logic [31:0]  mem_pend[$];

    int p_start, p_gnt, p_rv, p_rdy, p_redir;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit coin(input int p);
        return (int'($urandom_range(99)) < p);
    endfunction

    task automatic set_knobs(input int s, input int g, input int rv, input int rd, input int rdir);
        p_start = s; p_gnt = g; p_rv = rv; p_rdy = rd; p_redir = rdir;
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_pc  = RESET_PC;
        m_out.delete();
        m_q.delete();
        mem_pend.delete();
    endtask

    task automatic zero_inputs();
        start_i = 0; redirect_i = 0; redirect_pc_i = '0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = '0; inst_ready_i = 0;
    endtask

    // Asynchronous reset between edges, checked before any clock edge arrives
    task automatic async_reset(input int unsigned pre);
        #(pre);
        rst_i = 1'b0;
        zero_inputs();
        #1;
        check_val("rst_req",   imem_req_o,   32'd0);
        check_val("rst_addr",  imem_addr_o,  RESET_PC);
        check_val("rst_valid", inst_valid_o, 32'd0);
        check_val("rst_inst",  inst_o,       32'd0);
        check_val("rst_pc",    inst_pc_o,    32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    // One cycle per iteration: drive at posedge+1, check at posedge+3
    task automatic run_cycles(input int n);
        bit          exp_req, exp_valid, m_grant, dut_grant;
        logic [31:0] dut_addr;
        flight_t     r;
        for (int c = 0; c < n; c++) begin
            start_i       = coin(p_start);
            imem_gnt_i    = coin(p_gnt);
            inst_ready_i  = coin(p_rdy);
            redirect_i    = coin(p_redir);
            redirect_pc_i = $urandom();
            if (mem_pend.size() > 0 && coin(p_rv)) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_data(mem_pend[0]);
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = $urandom();
            end
            #2;
            exp_req   = m_run && ((m_q.size() + m_out.size()) < DEPTH);
            exp_valid = (m_q.size() > 0) && !redirect_i;
            check_val("req",   imem_req_o,   32'(exp_req));
            check_val("addr",  imem_addr_o,  m_pc);
            check_val("valid", inst_valid_o, 32'(exp_valid));
            if (exp_valid) begin
                check_val("inst",    inst_o,    m_q[0].inst);
                check_val("inst_pc", inst_pc_o, m_q[0].pc);
            end
            dut_grant = imem_req_o && imem_gnt_i;
            dut_addr  = imem_addr_o;
            m_grant   = exp_req && imem_gnt_i;

            @(posedge clk_i);
            if (exp_valid && inst_ready_i) void'(m_q.pop_front());
            if (m_grant) begin
                m_out.push_back('{pc: m_pc, drop: 1'b0});
                m_pc = m_pc + PC_STEP;
            end
            if (imem_rvalid_i && m_out.size() > 0) begin
                r = m_out.pop_front();
                if (!r.drop) m_q.push_back('{inst: mem_data(r.pc), pc: r.pc});
            end
            if (redirect_i) begin
                m_q.delete();
                foreach (m_out[i]) m_out[i].drop = 1'b1;
                m_pc = {redirect_pc_i[31:2], 2'b00};
            end
            m_run = start_i;
            if (imem_rvalid_i && mem_pend.size() > 0) void'(mem_pend.pop_front());
            if (dut_grant) mem_pend.push_back(dut_addr);
            #1;
        end
    endtask

    initial begin
        rst_i = 1'b1;
        zero_inputs();
        model_reset();
        async_reset(1);

        // Streaming: always granted, one-cycle response, decode always ready
        set_knobs(100, 100, 100, 100, 0);
        run_cycles(30);
        // Decode stalled: queue fills and requests stop, then drain
        set_knobs(100, 100, 100, 0, 0);
        run_cycles(20);
        set_knobs(100, 100, 100, 100, 0);
        run_cycles(20);
        // General random traffic with occasional redirects
        set_knobs(90, 60, 50, 60, 5);
        run_cycles(400);
        // Redirect-heavy, many drops and same-cycle grants
        set_knobs(95, 80, 70, 70, 30);
        run_cycles(300);
        // Start toggling, responses slow
        set_knobs(50, 70, 30, 50, 5);
        run_cycles(300);
        // Mid-stream asynchronous reset, then restart from RESET_PC
        set_knobs(100, 90, 80, 50, 0);
        run_cycles(25);
        async_reset(3);
        set_knobs(100, 100, 100, 100, 0);
        run_cycles(20);
        set_knobs(85, 50, 60, 40, 10);
        run_cycles(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch front-end directly upstream of the CPU decode/register stage.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions in a small in-order queue and hands {instruction, PC} to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all in-flight and buffered instructions.

Parameters:
DEPTH, 4, queue entries and also the maximum outstanding-request credit (power of two, at least 2)
RESET_PC, 32'h0000_0000, fetch PC after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  fetch enable, level-sensitive
redirect_i  input  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  input  32  redirect target; bits[1:0] ignored and forced to 0
imem_req_o  output  1  instruction memory request
imem_addr_o  output  32  request word address
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response valid; responses return in order, at least 1 cycle after grant
imem_rdata_i  input  32  response instruction
inst_valid_o  output  1  instruction available to decode
inst_o  output  32  instruction at queue head
inst_pc_o  output  32  PC of inst_o
inst_ready_i  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst_i=0, asynchronous) values:
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - fetch PC=RESET_PC; queue count, outstanding count and drop count all 0; FSM=IDLE.
- FSM:
  - IDLE: imem_req_o=0. Goes to RUN on the first clk edge with start_i=1.
  - RUN: issues requests. Returns to IDLE on an edge with start_i=0.
  - Leaving RUN stops new requests only. Outstanding responses are still accepted and queued, and decode may still drain the queue.
- Issue rule:
  - In RUN, imem_req_o=1 whenever queue_count + outstanding < DEPTH.
  - imem_addr_o = fetch PC.
- Grant:
  - On imem_req_o & imem_gnt_i: outstanding increments, fetch PC += PC_STEP (32-bit wrap at 0xFFFF_FFFC -> 0).
  - Ungranted request: addr and req stay stable unless a redirect occurs. The memory tolerates an address change before grant.
- Response:
  - On imem_rvalid_i with drop_count=0: push {rdata, PC of that request} to the queue and decrement outstanding.
  - The request PC is tracked in a PC queue parallel to the outstanding requests.
  - With drop_count>0: discard the response and decrement drop_count and outstanding.
  - The credit rule guarantees no overflow. A push to a full queue is an assertion failure.
- Decode handshake:
  - inst_valid_o = queue non-empty and not redirect_i.
  - Pop on inst_valid_o & inst_ready_i.
  - inst_o and inst_pc_o are the head entry, stable while valid and not ready.
  - A simultaneous push and pop keeps the count unchanged.
  - Latency: a response is visible on inst_valid_o the cycle after rvalid (registered queue, no bypass).
- Redirect, acting at the clk edge:
  - Queue is emptied.
  - drop_count = outstanding after this edge's grant/response updates, so a grant in the same cycle is counted and its response dropped.
  - Fetch PC = {redirect_pc_i[31:2],2'b00}. A same-cycle grant increment is overridden.
  - In the redirect cycle itself inst_valid_o=0, so no transfer occurs.
  - A new request to the target may issue the next cycle, subject to credit (drop_count entries consume credit).
- Redirect in IDLE: PC updated and queue flushed; no request issued.
- Back-to-back redirects: the last one wins; drop_count accumulates correctly.
- Reset mid-operation: all state cleared. Responses arriving after reset for pre-reset requests are a memory-side protocol violation and are not handled.

Decomposition:
- Package fetch_pkg holds:
  - the FSM state enum (IDLE, RUN)
  - the fetch entry typedef {inst[31:0], pc[31:0]}
  - constants RESET_PC_DEFAULT and PC_STEP_DEFAULT
- One sub-module, fetch_fifo: a parameterised DEPTH synchronous FIFO with push, pop, flush, count, full and empty.
  - Instantiated twice: instruction queue and in-flight PC queue.

Test Plan:
- Reset, then start_i=1, gnt always 1, rvalid 1 cycle after grant, ready=1 -> inst_pc_o sequence 0,4,8,12 on consecutive valid cycles, first valid 3 cycles after start.
- ready=0 held, DEPTH=4 -> exactly 4 grants (addr 0..12), then imem_req_o=0; queue full; ready=1 releases one new request per pop.
- Two requests outstanding (addr 0x10, 0x14), redirect to 0x103 -> both responses dropped, inst_valid_o stays 0, next imem_addr_o=0x100, first delivered inst_pc_o=0x100.
- Redirect in the same cycle as a grant of 0x20 -> response for 0x20 dropped; fetch resumes at the target, not the target+4.
- start_i deasserted with 2 outstanding -> no further req, both responses delivered in order, FSM IDLE; start_i=1 resumes at the next sequential PC.
- rst_i pulled low mid-stream asynchronously -> all outputs at reset values immediately; after release and start, fetch restarts at RESET_PC.
